mreq_rr_arbiter: RTL and testbench

//  N-to-1 arbiter for MREQ request streams with fair round-robin selection, burst locking and a registered output stage.

---
 rtl/mreq_rr_arbiter.sv | 135 +++++++++++++
 tb/tb_mreq_rr_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mreq_rr_arbiter.sv
// mreq_rr_arbiter: N-to-1 round-robin arbiter for MREQ request streams with burst locking and a registered output stage.
// Build option MREQ_ARB_PRIO0_EN: while idle, channel 0 overrides round-robin; locked bursts are never preempted.
`ifndef MREQ_NBIT
`define MREQ_NBIT 32
`endif

module mreq_rr_arbiter #(
  parameter int NUM_REQS = 3,
  parameter int DATA_W   = `MREQ_NBIT,
  localparam int IBITS   = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQS-1:0]        i_mreqs_valid,
  output logic [NUM_REQS-1:0]        o_mreqs_ready,
  input  logic [DATA_W*NUM_REQS-1:0] i_mreqs,
  input  logic [NUM_REQS-1:0]        i_mreqs_last,
  output logic                       o_mreq_valid,
  input  logic                       i_mreq_ready,
  output logic [DATA_W-1:0]          o_mreq,
  output logic [IBITS-1:0]           o_mreq_id,
  output logic                       o_mreq_last,
  output logic                       dbg_locked
);

  // Handshake (both sides): a beat moves on a rising edge where valid && ready are both 1;
  // valid and payload hold until then, and ready may depend combinationally on valid.

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [IBITS-1:0]   ptr, ptr_nxt;
  logic [IBITS-1:0]   lock_id, lock_id_nxt;
  logic [IBITS-1:0]   grant;
  logic               grant_valid;
  logic [DATA_W-1:0]  grant_word;
  logic               grant_last;
  logic               load;
  logic               xfer;

  assign load       = !o_mreq_valid || i_mreq_ready;
  assign xfer       = load && grant_valid && !rst;
  assign dbg_locked = (state == LOCKED);

  always_comb begin
    logic [IBITS:0] sum;
    grant       = '0;
    grant_valid = 1'b0;
    sum         = '0;
    if (state == LOCKED) begin
      grant       = lock_id;
      grant_valid = i_mreqs_valid[lock_id];
    end else begin
      // Walk from the farthest offset to the nearest so the first valid channel after ptr wins.
      for (int i = NUM_REQS; i >= 1; i--) begin
        sum = {1'b0, ptr} + (IBITS+1)'(i);
        if (sum >= (IBITS+1)'(NUM_REQS)) begin
          sum = sum - (IBITS+1)'(NUM_REQS);
        end
        if (i_mreqs_valid[sum[IBITS-1:0]]) begin
          grant       = sum[IBITS-1:0];
          grant_valid = 1'b1;
        end
      end
`ifdef MREQ_ARB_PRIO0_EN
      if (i_mreqs_valid[0]) begin
        grant       = '0;
        grant_valid = 1'b1;
      end
`endif
    end
  end

  always_comb begin
    grant_word = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      if (grant == IBITS'(k)) begin
        grant_word = i_mreqs[k*DATA_W +: DATA_W];
      end
    end
  end

  assign grant_last    = i_mreqs_last[grant];
  assign o_mreqs_ready = xfer ? (NUM_REQS'(1) << grant) : '0;

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    lock_id_nxt = lock_id;
    if (xfer) begin
`ifdef MREQ_ARB_PRIO0_EN
      // Channel-0 wins do not disturb the rotation among the other channels.
      if (grant != '0) begin
        ptr_nxt = grant;
      end
`else
      ptr_nxt = grant;
`endif
      if (grant_last) begin
        state_nxt = IDLE;
      end else begin
        state_nxt   = LOCKED;
        lock_id_nxt = grant;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= IBITS'(NUM_REQS - 1);
      lock_id      <= '0;
      o_mreq_valid <= 1'b0;
      o_mreq       <= '0;
      o_mreq_id    <= '0;
      o_mreq_last  <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      lock_id <= lock_id_nxt;
      if (load) begin
        o_mreq_valid <= grant_valid;
      end
      if (xfer) begin
        o_mreq      <= grant_word;
        o_mreq_id   <= grant;
        o_mreq_last <= grant_last;
      end
    end
  end

endmodule

// File: tb/tb_mreq_rr_arbiter.sv
// tb_mreq_rr_arbiter: randomized and directed bench for mreq_rr_arbiter against a behavioural arbitration model.
// Honors MREQ_ARB_PRIO0_EN the same way as the design.
`timescale 1ns/1ps

module tb_mreq_rr_arbiter;

  localparam int N  = 3;
  localparam int W  = 16;
  localparam int IB = 2;

  // ---------------- clock / reset ----------------
  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   i_mreqs_valid;
  logic [N-1:0]   o_mreqs_ready;
  logic [N*W-1:0] i_mreqs;
  logic [N-1:0]   i_mreqs_last;
  logic           o_mreq_valid;
  logic           i_mreq_ready;
  logic [W-1:0]   o_mreq;
  logic [IB-1:0]  o_mreq_id;
  logic           o_mreq_last;
  logic           dbg_locked;

  always #5 clk = ~clk;

  mreq_rr_arbiter #(.NUM_REQS(N), .DATA_W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_mreqs_valid(i_mreqs_valid),
    .o_mreqs_ready(o_mreqs_ready),
    .i_mreqs      (i_mreqs),
    .i_mreqs_last (i_mreqs_last),
    .o_mreq_valid (o_mreq_valid),
    .i_mreq_ready (i_mreq_ready),
    .o_mreq       (o_mreq),
    .o_mreq_id    (o_mreq_id),
    .o_mreq_last  (o_mreq_last),
    .dbg_locked   (dbg_locked)
  );

  typedef struct packed {
    logic         idle;
    logic         last;
    logic [W-1:0] data;
  } item_t;

  item_t        src_q[N][$];
  logic [N-1:0] pres;
  logic [N-1:0] acc;
  logic         rand_on = 1'b0;
  int           out_log[$];
  logic [W-1:0] exp_q[$];
  int           n_vec = 0;
  int           n_err = 0;

  // ---------------- behavioural model ----------------
  int           m_ptr;
  int           m_lock;
  logic         m_valid;
  logic [W-1:0] m_word;
  int           m_id;
  logic         m_last;
  bit           model_live = 1'b0;

  // Which channel the rules allow this cycle, or -1.
  function automatic int model_grant();
    int g;
    int c;
    g = -1;
    if (m_lock >= 0) begin
      if (i_mreqs_valid[m_lock]) g = m_lock;
    end else begin
`ifdef MREQ_ARB_PRIO0_EN
      if (i_mreqs_valid[0]) g = 0;
`endif
      for (int i = 1; i <= N; i++) begin
        c = (m_ptr + i) % N;
        if (g < 0 && i_mreqs_valid[c]) g = c;
      end
    end
    return g;
  endfunction

  always @(posedge clk) begin
    int g;
    acc = i_mreqs_valid & o_mreqs_ready;
    if (o_mreq_valid && i_mreq_ready && !rst) out_log.push_back(int'(o_mreq_id));
    if (rst) begin
      m_ptr   = N - 1;
      m_lock  = -1;
      m_valid = 1'b0;
      m_word  = '0;
      m_id    = 0;
      m_last  = 1'b0;
    end else begin
      g = model_grant();
      if (!m_valid || i_mreq_ready) begin
        m_valid = (g >= 0);
        if (g >= 0) begin
          m_word = i_mreqs[g*W +: W];
          m_id   = g;
          m_last = i_mreqs_last[g];
`ifdef MREQ_ARB_PRIO0_EN
          if (g != 0) m_ptr = g;
`else
          m_ptr = g;
`endif
          m_lock = i_mreqs_last[g] ? -1 : g;
        end
      end
    end
    model_live = 1'b1;
  end

  // ---------------- scoreboard / compare ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int g;
    logic [N-1:0] er;
    if (model_live) begin
      g  = model_grant();
      er = '0;
      if (!rst && (!m_valid || i_mreq_ready) && g >= 0) er[g] = 1'b1;
      check("ready", 32'(o_mreqs_ready), 32'(er));
      check("valid", 32'(o_mreq_valid), 32'(m_valid));
      if (m_valid) begin
        check("word", 32'(o_mreq), 32'(m_word));
        check("id", 32'(o_mreq_id), 32'(m_id));
        check("last", 32'(o_mreq_last), 32'(m_last));
      end
    end
  end

  task automatic exp_add(input int id, input int cnt);
    for (int i = 0; i < cnt; i++) exp_q.push_back(W'(id));
  endtask

  task automatic compare_log(input string name);
    check({name, "_len"}, 32'(out_log.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < out_log.size(); i++)
      check(name, 32'(out_log[i]), 32'(exp_q[i]));
    out_log.delete();
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  function automatic item_t mk(input logic idle, input logic last, input logic [W-1:0] data);
    item_t it;
    it.idle = idle;
    it.last = last;
    it.data = data;
    return it;
  endfunction

  task automatic push_beat(input int k, input logic last);
    src_q[k].push_back(mk(1'b0, last, W'($urandom)));
  endtask

  task automatic push_idle(input int k, input int cnt);
    for (int i = 0; i < cnt; i++) src_q[k].push_back(mk(1'b1, 1'b0, '0));
  endtask

  // Advance one clock; sources retire accepted beats and present their next item.
  task automatic tick();
    item_t tmp;
    int len;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (pres[k] && (src_q[k][0].idle || acc[k])) tmp = src_q[k].pop_front();
      if (rand_on && src_q[k].size() < 2) begin
        len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++) begin
          if ($urandom_range(0, 4) == 0) push_idle(k, 1);
          push_beat(k, b == len - 1);
        end
      end
      if (src_q[k].size() > 0) begin
        pres[k]             = 1'b1;
        i_mreqs_valid[k]    = !src_q[k][0].idle;
        i_mreqs_last[k]     = src_q[k][0].last;
        i_mreqs[k*W +: W]   = src_q[k][0].data;
      end else begin
        pres[k]          = 1'b0;
        i_mreqs_valid[k] = 1'b0;
        i_mreqs_last[k]  = 1'b0;
      end
    end
    if (rand_on) i_mreq_ready = ($urandom_range(0, 9) < 7);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((src_q[0].size() + src_q[1].size() + src_q[2].size() != 0 || o_mreq_valid || |i_mreqs_valid)
           && n < 300) begin
      tick();
      n++;
    end
    check("drain_timeout", 32'(n >= 300), 32'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before 500us");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1);
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    rst           = 1'b1;
    i_mreq_ready  = 1'b1;
    i_mreqs_valid = '0;
    i_mreqs       = '0;
    i_mreqs_last  = '0;
    pres          = '0;

    // Reset with every channel requesting, then fair rotation once released.
    for (int k = 0; k < N; k++) begin
      push_beat(k, 1'b1);
      push_beat(k, 1'b1);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      @(negedge clk);
      check("rst_valid", 32'(o_mreq_valid), 32'(0));
      check("rst_ready", 32'(o_mreqs_ready), 32'(0));
      check("rst_word", 32'(o_mreq), 32'(0));
      check("rst_id", 32'(o_mreq_id), 32'(0));
      check("rst_last", 32'(o_mreq_last), 32'(0));
    end
    rst = 1'b0;
    wait_idle();
`ifdef MREQ_ARB_PRIO0_EN
    exp_add(0, 2); exp_add(1, 1); exp_add(2, 1); exp_add(1, 1); exp_add(2, 1);
`else
    exp_add(0, 1); exp_add(1, 1); exp_add(2, 1); exp_add(0, 1); exp_add(1, 1); exp_add(2, 1);
`endif
    compare_log("fair_ids");

    // Backpressure: a ch1 beat is held while the sink stalls.
    src_q[1].push_back(mk(1'b0, 1'b1, 16'h00A5));
    push_idle(0, 1); push_beat(0, 1'b1);
    push_idle(2, 1); push_beat(2, 1'b1);
    i_mreq_ready = 1'b0;
    tick();
    tick();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("hold_valid", 32'(o_mreq_valid), 32'(1));
      check("hold_word", 32'(o_mreq), 32'h00A5);
      check("hold_id", 32'(o_mreq_id), 32'(1));
      check("hold_ready", 32'(o_mreqs_ready), 32'(0));
      check("hold_lock", 32'(dbg_locked), 32'(0));
      tick();
    end
    i_mreq_ready = 1'b1;
    wait_idle();
    exp_add(1, 1);
`ifdef MREQ_ARB_PRIO0_EN
    exp_add(0, 1); exp_add(2, 1);
`else
    exp_add(2, 1); exp_add(0, 1);
`endif
    compare_log("stall_ids");

    // Burst lock on ch2 with a valid gap while ch0/ch1 wait.
    push_beat(2, 1'b0); push_beat(2, 1'b0); push_idle(2, 2); push_beat(2, 1'b0); push_beat(2, 1'b1);
    push_idle(0, 1); push_beat(0, 1'b1);
    push_idle(1, 1); push_beat(1, 1'b1);
    wait_idle();
    exp_add(2, 4); exp_add(0, 1); exp_add(1, 1);
    compare_log("burst_ids");

    // Sparse: ch1 alone for 10 beats, then ch0 and ch2 join.
    for (int i = 0; i < 10; i++) push_beat(1, 1'b1);
    push_idle(0, 10); push_beat(0, 1'b1);
    push_idle(2, 10); push_beat(2, 1'b1);
    wait_idle();
    exp_add(1, 10);
`ifdef MREQ_ARB_PRIO0_EN
    exp_add(0, 1); exp_add(2, 1);
`else
    exp_add(2, 1); exp_add(0, 1);
`endif
    compare_log("sparse_ids");

    // ch0 and ch1 competing with single-beat requests.
    for (int i = 0; i < 4; i++) begin
      push_beat(0, 1'b1);
      push_beat(1, 1'b1);
    end
    wait_idle();
`ifdef MREQ_ARB_PRIO0_EN
    exp_add(0, 4); exp_add(1, 4);
`else
    for (int i = 0; i < 4; i++) begin
      exp_add(1, 1); exp_add(0, 1);
    end
`endif
    compare_log("pair_ids");

    // ch0 arrives during a ch1 burst and must wait for its end.
    push_beat(1, 1'b0); push_beat(1, 1'b0); push_beat(1, 1'b1);
    push_idle(0, 1); push_beat(0, 1'b1);
    wait_idle();
    exp_add(1, 3); exp_add(0, 1);
    compare_log("nopreempt_ids");

    // Random traffic with sink stalls and one reset in the middle.
    rand_on = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) rst = 1'b1;
      if (i == 1502) rst = 1'b0;
      tick();
    end
    rand_on      = 1'b0;
    i_mreq_ready = 1'b1;
    wait_idle();
    out_log.delete();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
